// File: rtl/collision_detect.sv
// collision_detect: upstream stage of the ball mover.
//
// Takes the ball's proposed next position and direction, tests it against the
// walls, the brick map and the paddle in a fixed four-state scan, and returns
// one-cycle reflection pulses on the REPORT cycle. Owns the brick map and the
// live-brick count, and flags level clear / ball lost to the game FSM.
//
// Optional feature macro: SCORE_EN (adds a 16-bit saturating score output).
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   check              start-of-test pulse, accepted only when idle
//   nextX, nextY       proposed ball position (latched on accept)
//   dirX, dirY         1 = moving left / moving up (latched on accept)
//   paddleX            paddle left edge (latched on accept)
//   refill             restore all bricks and abort any scan in flight
//   busy, done         scan in progress / results valid pulse
//   cX, cY             wall-x reflection / top-wall-or-paddle reflection
//   cBrickX, cBrickY   brick reflection pulses
//   brick_hit          a brick was destroyed this scan
//   lose               ball reached the bottom row
//   level_clear        the last brick was destroyed this scan
//   bricks_left        live brick count
//   score              (SCORE_EN only) accumulated points
module collision_detect #(
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int ROWS         = 4,
    parameter int COLS         = 10,
    parameter int BRICK_W_LOG2 = 4,
    parameter int BRICK_H_LOG2 = 3,
    parameter int BRICK_TOP    = 8,
    parameter int PADDLE_Y     = 112,
    parameter int PADDLE_W     = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        check,
    input  logic [7:0]  nextX,
    input  logic [7:0]  nextY,
    input  logic        dirX,
    input  logic        dirY,
    input  logic [7:0]  paddleX,
    input  logic        refill,
    output logic        busy,
    output logic        done,
    output logic        cX,
    output logic        cY,
    output logic        cBrickX,
    output logic        cBrickY,
    output logic        brick_hit,
    output logic        lose,
    output logic        level_clear,
    output logic [7:0]  bricks_left
`ifdef SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    localparam int NB = ROWS * COLS;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    // All geometry compares are done 9 bits wide so edge sums never wrap.
    localparam logic [8:0] X_MAX   = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_MAX   = 9'(SCREEN_H - 1);
    localparam logic [8:0] BR_Y0   = 9'(BRICK_TOP);
    localparam logic [8:0] BR_Y1   = 9'(BRICK_TOP + (ROWS << BRICK_H_LOG2));
    localparam logic [8:0] BR_X1   = 9'(COLS << BRICK_W_LOG2);
    localparam logic [8:0] PAD_Y   = 9'(PADDLE_Y);
    localparam logic [8:0] PAD_WM1 = 9'(PADDLE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WALL   = 3'd1,
        S_BRICK  = 3'd2,
        S_PADDLE = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t state, nxt;

    // Latched request
    logic [7:0] lx, ly, lpx;
    logic       ldx, ldy;

    // Per-scan result flags, each written in its own state
    logic f_x, f_top, f_lose, f_pad;
    logic f_hit, f_bx, f_by, f_clr;

    logic [NB-1:0] bricks;

    // ---------------- brick decode on the latched position ----------------
    logic [8:0]                xw, yw;
    logic                      in_region, alive;
    logic [7:0]                yrel;
    logic [RW-1:0]             row;
    logic [CW-1:0]             col;
    logic [IW-1:0]             bidx;
    logic [BRICK_H_LOG2-1:0]   yoff;
    logic [BRICK_W_LOG2-1:0]   xoff;
    logic                      y_edge, x_edge, pad_hit;

    always_comb begin
        xw        = {1'b0, lx};
        yw        = {1'b0, ly};
        in_region = (yw >= BR_Y0) && (yw < BR_Y1) && (xw < BR_X1);
        yrel      = ly - 8'(BRICK_TOP);
        row       = RW'(yrel >> BRICK_H_LOG2);
        col       = CW'(lx >> BRICK_W_LOG2);
        bidx      = IW'(row) * IW'(COLS) + IW'(col);
        // in_region gates the lookup so an out-of-map index is never used
        alive     = in_region && bricks[bidx];
        yoff      = yrel[BRICK_H_LOG2-1:0];
        xoff      = lx[BRICK_W_LOG2-1:0];
        y_edge    = (yoff == '0) || (yoff == '1);
        x_edge    = (xoff == '0) || (xoff == '1);
        pad_hit   = (yw == PAD_Y) && !ldy &&
                    (xw >= {1'b0, lpx}) && (xw <= ({1'b0, lpx} + PAD_WM1));
    end

`ifdef SCORE_EN
    // Row 0 is worth ROWS points, the bottom row 1 point.
    logic [15:0] pts;
    logic [16:0] score_sum;
    always_comb begin
        pts       = 16'(ROWS) - 16'(row);
        score_sum = {1'b0, score} + {1'b0, pts};
    end
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (refill) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (check) nxt = S_WALL;
                S_WALL:   nxt = S_BRICK;
                S_BRICK:  nxt = S_PADDLE;
                S_PADDLE: nxt = S_REPORT;
                S_REPORT: nxt = S_IDLE;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lx          <= '0;
            ly          <= '0;
            lpx         <= '0;
            ldx         <= 1'b0;
            ldy         <= 1'b0;
            f_x         <= 1'b0;
            f_top       <= 1'b0;
            f_lose      <= 1'b0;
            f_pad       <= 1'b0;
            f_hit       <= 1'b0;
            f_bx        <= 1'b0;
            f_by        <= 1'b0;
            f_clr       <= 1'b0;
            bricks      <= '1;
            bricks_left <= 8'(NB);
`ifdef SCORE_EN
            score       <= '0;
`endif
        end else if (refill) begin
            bricks      <= '1;
            bricks_left <= 8'(NB);
`ifdef SCORE_EN
            score       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (check) begin
                    lx  <= nextX;
                    ly  <= nextY;
                    ldx <= dirX;
                    ldy <= dirY;
                    lpx <= paddleX;
                end
                S_WALL: begin
                    f_x    <= ((lx == 8'd0) && ldx) || ((xw >= X_MAX) && !ldx);
                    f_top  <= (ly == 8'd0) && ldy;
                    f_lose <= (yw >= Y_MAX);
                end
                S_BRICK: begin
                    f_hit <= alive;
                    f_bx  <= alive && x_edge;
                    // interior hits default to a vertical bounce
                    f_by  <= alive && (y_edge || !x_edge);
                    f_clr <= alive && (bricks_left == 8'd1);
                    if (alive && (bricks_left != 8'd0)) begin
                        bricks[bidx] <= 1'b0;
                        bricks_left  <= bricks_left - 8'd1;
`ifdef SCORE_EN
                        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    end
                end
                S_PADDLE: f_pad <= pad_hit;
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    logic rep;
    assign rep         = (state == S_REPORT);
    assign busy        = (state != S_IDLE);
    assign done        = rep;
    assign cX          = rep && f_x;
    assign cY          = rep && (f_top || f_pad);
    assign cBrickX     = rep && f_bx;
    assign cBrickY     = rep && f_by;
    assign brick_hit   = rep && f_hit;
    assign lose        = rep && f_lose;
    assign level_clear = rep && f_clr;

endmodule

// File: tb/tb_collision_detect.sv
module tb_collision_detect;

    localparam int ROWS = 4;
    localparam int COLS = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       check = 1'b0;
    logic [7:0] nextX = '0, nextY = '0, paddleX = '0;
    logic       dirX = 1'b0, dirY = 1'b0;
    logic       refill = 1'b0;
    logic       busy, done, cX, cY, cBrickX, cBrickY, brick_hit, lose, level_clear;
    logic [7:0] bricks_left;
`ifdef SCORE_EN
    logic [15:0] score;
`endif

    collision_detect dut (
        .clock(clock), .reset(reset), .check(check),
        .nextX(nextX), .nextY(nextY), .dirX(dirX), .dirY(dirY),
        .paddleX(paddleX), .refill(refill),
        .busy(busy), .done(done), .cX(cX), .cY(cY),
        .cBrickX(cBrickX), .cBrickY(cBrickY), .brick_hit(brick_hit),
        .lose(lose), .level_clear(level_clear), .bricks_left(bricks_left)
`ifdef SCORE_EN
        , .score(score)
`endif
    );

    always #5 clock = ~clock;

    int ncmp = 0;
    int nerr = 0;

    // Reference model: the brick wall as a 2-D array plus counters.
    bit m_alive [ROWS][COLS];
    int m_left;
    int m_score;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_refill();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_alive[r][c] = 1'b1;
        m_left  = ROWS * COLS;
        m_score = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".done"}, 16'(done), 16'd0);
        chk({tag, ".cX"}, 16'(cX), 16'd0);
        chk({tag, ".cY"}, 16'(cY), 16'd0);
        chk({tag, ".cBX"}, 16'(cBrickX), 16'd0);
        chk({tag, ".cBY"}, 16'(cBrickY), 16'd0);
        chk({tag, ".hit"}, 16'(brick_hit), 16'd0);
        chk({tag, ".lose"}, 16'(lose), 16'd0);
        chk({tag, ".clr"}, 16'(level_clear), 16'd0);
    endtask

    // One full scan: model predicts, DUT runs, every cycle is checked.
    task automatic do_check(input int x, input int y, input bit dx, input bit dy, input int px);
        bit e_cx, e_cy, e_bx, e_by, e_hit, e_lose, e_clr;
        int r, c, yo, xo;
        e_cx   = (x == 0 && dx) || (x >= 159 && !dx);
        e_lose = (y >= 119);
        e_cy   = (y == 0 && dy) || (y == 112 && !dy && x >= px && x <= px + 23);
        e_hit = 0; e_bx = 0; e_by = 0; e_clr = 0;
        if (y >= 8 && y < 40 && x < 160) begin
            r = (y - 8) / 8;  c = x / 16;
            yo = (y - 8) % 8; xo = x % 16;
            if (m_alive[r][c]) begin
                m_alive[r][c] = 1'b0;
                m_left--;
                m_score += ROWS - r;
                if (m_score > 65535) m_score = 65535;
                e_hit = 1;
                e_by  = (yo == 0 || yo == 7);
                e_bx  = (xo == 0 || xo == 15);
                if (!e_by && !e_bx) e_by = 1;
                e_clr = (m_left == 0);
            end
        end

        @(negedge clock);
        check = 1'b1; nextX = 8'(x); nextY = 8'(y); dirX = dx; dirY = dy; paddleX = 8'(px);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            // scramble inputs after acceptance; one stray check mid-scan must be ignored
            check   = (k == 1);
            nextX   = 8'($urandom); nextY = 8'($urandom);
            dirX    = 1'($urandom); dirY  = 1'($urandom);
            paddleX = 8'($urandom);
            chk("busy", 16'(busy), 16'(k < 4));
            if (k == 3) begin
                chk("done", 16'(done), 16'd1);
                chk("cX", 16'(cX), 16'(e_cx));
                chk("cY", 16'(cY), 16'(e_cy));
                chk("cBrickX", 16'(cBrickX), 16'(e_bx));
                chk("cBrickY", 16'(cBrickY), 16'(e_by));
                chk("brick_hit", 16'(brick_hit), 16'(e_hit));
                chk("lose", 16'(lose), 16'(e_lose));
                chk("level_clear", 16'(level_clear), 16'(e_clr));
                chk("bricks_left", 16'(bricks_left), 16'(m_left));
`ifdef SCORE_EN
                chk("score", score, 16'(m_score));
`endif
            end else begin
                chk_idle_outputs("quiet");
            end
        end
        check = 1'b0;
    endtask

    task automatic do_refill();
        @(negedge clock);
        refill = 1'b1;
        @(posedge clock);
        @(negedge clock);
        refill = 1'b0;
        model_refill();
        chk("refill.left", 16'(bricks_left), 16'(m_left));
        chk("refill.busy", 16'(busy), 16'd0);
    endtask

    initial begin
        int x, y, px, mode;
        bit dx, dy;
        model_refill();

        // reset
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst.left", 16'(bricks_left), 16'd40);
        chk("rst.busy", 16'(busy), 16'd0);
        chk_idle_outputs("rst");
`ifdef SCORE_EN
        chk("rst.score", score, 16'd0);
`endif
        reset = 1'b1;
        @(negedge clock);
        chk("rel.busy", 16'(busy), 16'd0);
        chk_idle_outputs("rel");

        // left wall
        do_check(0, 60, 1, 0, 0);
        // brick row0 col1 top edge, then the same spot again (now dead)
        do_check(20, 8, 0, 1, 0);
        do_check(20, 8, 0, 1, 0);
        // paddle edges
        do_check(60, 112, 0, 0, 50);
        do_check(74, 112, 0, 0, 50);
        do_check(73, 112, 0, 0, 50);
        do_check(50, 112, 0, 0, 50);
        do_check(60, 112, 0, 1, 50);
        // paddle near right of range: sum must not wrap
        do_check(255, 112, 1, 0, 240);
        // right wall, top wall, bottom row
        do_check(159, 30, 0, 1, 0);
        do_check(159, 30, 1, 1, 0);
        do_check(80, 0, 0, 1, 0);
        do_check(80, 119, 0, 0, 0);
        // brick corner and side edge
        do_check(47, 23, 1, 0, 0);
        do_check(64, 36, 0, 0, 0);

        // refill together with check: refill wins, nothing starts
        @(negedge clock);
        refill = 1'b1; check = 1'b1; nextX = 8'd20; nextY = 8'd8;
        @(posedge clock);
        @(negedge clock);
        refill = 1'b0; check = 1'b0;
        model_refill();
        chk("rc.busy", 16'(busy), 16'd0);
        chk("rc.left", 16'(bricks_left), 16'd40);

        // refill while in BRICK aborts the scan and keeps the map full
        @(negedge clock);
        check = 1'b1; nextX = 8'd20; nextY = 8'd12; dirX = 1'b0; dirY = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check = 1'b0;
        @(posedge clock);
        @(negedge clock);
        refill = 1'b1;
        @(posedge clock);
        @(negedge clock);
        refill = 1'b0;
        chk("abort.busy", 16'(busy), 16'd0);
        chk("abort.left", 16'(bricks_left), 16'd40);
        chk_idle_outputs("abort0");
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk_idle_outputs("abort");
        end

        // randomized scans
        for (int n = 0; n < 200; n++) begin
            mode = int'($urandom_range(0, 3));
            px = int'($urandom_range(0, 255));
            dx = 1'($urandom); dy = 1'($urandom);
            case (mode)
                0: begin x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255)); end
                1: begin x = int'($urandom_range(0, 170)); y = int'($urandom_range(0, 47)); end
                2: begin x = int'($urandom_range(0, 255)); y = 112;
                         px = (x > 30) ? x - int'($urandom_range(0, 30)) : 0; end
                default: begin
                    x = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(158, 160));
                    y = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(118, 120));
                end
            endcase
            do_check(x, y, dx, dy, px);
        end

        // clear the whole wall from a full map
        do_refill();
`ifdef SCORE_EN
        do_check(8, 12, 0, 0, 0);
        chk("score.row0", score, 16'd4);
`endif
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                do_check(c * 16 + 8, 8 + r * 8 + 4, 0, 1, 0);
        chk("clear.left", 16'(bricks_left), 16'd0);
        // nothing left to hit: count stays at zero
        do_check(24, 20, 0, 1, 0);
        chk("empty.left", 16'(bricks_left), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
Name: collision_detect

Overview:
Upstream stage of the ball mover. Takes the ball's proposed next position (nextX/nextY) and direction, checks it against the walls, the paddle and a register-held brick map, and returns one-cycle reflection pulses (cX, cY, cBrickX, cBrickY) for the ball stage to use. Owns the brick map and the bricks-remaining count, and signals level clear and ball lost to the top-level game FSM.

Parameters:
SCREEN_W, 160, playfield width in pixels (x range 0..SCREEN_W-1)
SCREEN_H, 120, playfield height in pixels (y range 0..SCREEN_H-1)
ROWS, 4, brick rows
COLS, 10, brick columns
BRICK_W_LOG2, 4, brick width = 2^BRICK_W_LOG2 = 16 px
BRICK_H_LOG2, 3, brick height = 2^BRICK_H_LOG2 = 8 px
BRICK_TOP, 8, y of brick row 0 top edge
PADDLE_Y, 112, paddle top-surface row
PADDLE_W, 24, paddle width in pixels

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
check  in  1  start-of-test pulse; accepted only when busy=0
nextX  in  8  proposed ball x
nextY  in  8  proposed ball y
dirX  in  1  1 = moving left (x decreasing)
dirY  in  1  1 = moving up (y decreasing)
paddleX  in  8  paddle left edge
refill  in  1  synchronous: restore all bricks, abort scan
busy  out  1  high while scan is in progress
done  out  1  one-cycle pulse, results valid
cX  out  1  wall x reflection pulse
cY  out  1  top-wall or paddle y reflection pulse
cBrickX  out  1  brick x reflection pulse
cBrickY  out  1  brick y reflection pulse
brick_hit  out  1  one-cycle pulse, a brick was destroyed
lose  out  1  one-cycle pulse, ball reached bottom row
level_clear  out  1  one-cycle pulse, last brick destroyed
bricks_left  out  8  live brick count

Behaviour:
- Reset (reset=0, async): every brick alive, bricks_left = ROWS*COLS, FSM in IDLE, all pulse outputs 0, busy 0.
- FSM: IDLE -> WALL -> BRICK -> PADDLE -> REPORT -> IDLE, one cycle per state.
- check is accepted in IDLE only. nextX, nextY, dirX, dirY and paddleX are latched on acceptance. check is ignored while busy.
- busy = 1 in WALL through REPORT. done and all result pulses assert for exactly the REPORT cycle, 4 cycles after the check cycle. All are 0 otherwise.
- WALL:
  - x flag if (x==0 and dirX=1) or (x>=SCREEN_W-1 and dirX=0).
  - top flag if y==0 and dirY=1.
  - lose flag if y>=SCREEN_H-1. No cY is raised for the bottom row.
- BRICK: the brick region is BRICK_TOP <= y < BRICK_TOP+ROWS*2^H and x < COLS*2^W.
  - Indexing: row = (y-BRICK_TOP)>>H, col = x>>W, yoff and xoff = low bits.
  - If the addressed brick is alive, clear it in the BRICK cycle and decrement bricks_left.
  - Reflection: cBrickY if yoff is 0 or 2^H-1. cBrickX if xoff is 0 or 2^W-1. Both may assert at a corner. If neither applies, cBrickY.
  - If the brick is dead, no flags are raised.
- PADDLE: paddle flag if y==PADDLE_Y, dirY=0, and paddleX <= x <= paddleX+PADDLE_W-1. The sum is computed 9-bit, so there is no wrap.
- REPORT outputs:
  - cX = wall x flag.
  - cY = top flag OR paddle flag.
  - brick_hit is pulsed with the brick flags.
  - level_clear pulses if bricks_left became 0 on this hit.
  - lose pulses if the lose flag was set.
- bricks_left never underflows. At 0, no brick is alive, so no decrement occurs.
- refill (any state): all bricks alive, bricks_left full, FSM to IDLE, no REPORT pulses for the aborted scan. refill has priority over a simultaneous check.

Optional Feature:
SCORE_EN.
- Defined: adds output score (16 bits), reset to 0 and cleared by refill. Each brick hit adds ROWS-row points (row 0 = ROWS points), saturating at 16'hFFFF. score updates in the same cycle as bricks_left.
- Undefined: no score port and no score logic.

Test Plan:
- Reset release -> bricks_left=40, busy=0, all pulses 0.
- check with nextX=0, dirX=1, nextY=60 -> busy 4 cycles; cX=1 and done=1 for exactly one cycle, 4 cycles after check; cY=0.
- check at (20,8), dirY=1 (row0 col1, yoff=0) -> cBrickY=1, brick_hit=1, bricks_left=39. Repeat same check -> no brick flags, bricks_left stays 39.
- paddleX=50, (60,112), dirY=0 -> cY=1. (74,112) -> cY=0. (73,112) -> cY=1.
- check at y=119 -> lose=1, cY=0. refill asserted in BRICK state mid-scan -> no done, bricks_left=40, busy=0 next cycle.
- Destroy all 40 bricks -> level_clear on the 40th hit only, bricks_left=0. With SCORE_EN, one row-0 hit -> score=4.
